// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream instruction memory loader
//
// Purpose: receives a 16-bit little-endian word count followed by two bytes
// per 9-bit instruction word, writes the words to instruction memory at
// addresses 0..N-1, and holds the core in reset until the image is complete.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   reset      - asynchronous active-low reset
//   start      - one-cycle pulse, begins a new load when not busy
//   in_valid   - in_data carries a byte
//   in_data    - stream byte
//   in_ready   - loader accepts a byte this cycle
//   im_wr_en   - instruction memory write strobe, one cycle per word
//   im_addr    - instruction memory write address
//   im_dat     - instruction word to write
//   core_hold  - 1 keeps the core in reset
//   busy       - load in progress
//   load_done  - image complete, held until the next accepted start
//   err        - header count exceeded memory depth, held until next start
module prog_loader #(
  parameter int D             = 10,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         im_wr_en,
  output logic [D-1:0] im_addr,
  output logic [8:0]   im_dat,
  output logic         core_hold,
  output logic         busy,
  output logic         load_done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, W_LO, W_HI, DONE, ERR
  } state_t;

  localparam logic [16:0]  DEPTH    = 17'd1 << D;
  localparam logic [D:0]   CNT_ONE  = 1;
  localparam logic [D-1:0] ADDR_ONE = 1;

  state_t       state, state_next;
  logic [7:0]   cnt_lo;
  logic [7:0]   w_lo;
  logic [D:0]   total;
  logic         accept;
  logic         start_acc;
  logic         last_word;
  logic [15:0]  cnt_full;

  assign in_ready  = (state inside {CNT_LO, CNT_HI, W_LO, W_HI});
  assign busy      = in_ready;
  assign load_done = (state == DONE);
  assign err       = (state == ERR);

  assign accept    = in_valid && in_ready;
  assign start_acc = start && (state inside {IDLE, DONE, ERR});
  assign cnt_full  = {in_data, cnt_lo};
  // im_addr already holds the index of the word being completed, so it
  // doubles as the word counter.
  assign last_word = (({1'b0, im_addr} + CNT_ONE) == total);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = CNT_LO;
      CNT_LO:          if (accept) state_next = CNT_HI;
      CNT_HI: begin
        if (accept) begin
          if (cnt_full == 16'd0)              state_next = DONE;
          else if ({1'b0, cnt_full} > DEPTH)  state_next = ERR;
          else                                state_next = W_LO;
        end
      end
      W_LO:            if (accept) state_next = W_HI;
      W_HI:            if (accept) state_next = last_word ? DONE : W_LO;
      default:         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_wr_en  <= 1'b0;
      im_addr   <= '0;
      im_dat    <= '0;
      core_hold <= HOLD_AT_RESET;
      cnt_lo    <= '0;
      w_lo      <= '0;
      total     <= '0;
    end else if (start_acc) begin
      im_wr_en  <= 1'b0;
      im_addr   <= '0;
      core_hold <= 1'b1;
    end else begin
      im_wr_en <= 1'b0;
      // Advance past the word just written; the final word leaves the
      // address on the last location so it never exceeds D bits.
      if (im_wr_en && state != DONE) im_addr <= im_addr + ADDR_ONE;
      if (state == CNT_LO && accept) cnt_lo <= in_data;
      if (state == CNT_HI && accept) total  <= cnt_full[D:0];
      if (state == W_LO && accept)   w_lo   <= in_data;
      if (state == W_HI && accept) begin
        im_dat   <= {in_data[0], w_lo};
        im_wr_en <= 1'b1;
      end
      // In DONE any final write pulse ends on this same edge, so the core
      // is released only once the last word is in memory.
      if (state == DONE) core_hold <= 1'b0;
    end
  end

endmodule
